// File: rtl/rx_frame_seq.sv
// Receive frame sequencer: finds frames by preamble/SFD/idle gap, checks the Ethernet
// header and emits the payload with the FCS stripped. Optional RX_MAC_FILTER_EN adds a dest-MAC filter.
module rx_frame_seq #(
  parameter int unsigned IDLE_TIMEOUT = 4,
  parameter logic [15:0] ETHERTYPE    = 16'h0800,
  parameter int unsigned MAX_PAYLOAD  = 1500,
  parameter int unsigned MIN_PAYLOAD  = 46,
  parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic [7:0]  dataIn,
  input  logic        dataValidIn,
  output logic [7:0]  payloadDataOut,
  output logic        payloadValidOut,
  output logic        payloadFirstOut,
  output logic        frameEndOut,
  output logic [10:0] frameLenOut,
  output logic        frameErrOut,
  output logic [15:0] dropCntOut,
  output logic        busyOut
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_DROP} state_t;

  localparam logic [3:0]  IDLE_LAST = 4'(IDLE_TIMEOUT - 1);
  localparam logic [10:0] MAX_LEN   = 11'(MAX_PAYLOAD);
  localparam logic [10:0] MIN_LEN   = 11'(MIN_PAYLOAD);

  state_t           state_q, state_d;
  logic [2:0]       pre_cnt_q, pre_cnt_d;
  logic [3:0]       hdr_cnt_q, hdr_cnt_d;
  logic [7:0]       etype_hi_q, etype_hi_d;
  logic [3:0][7:0]  dly_q, dly_d;
  logic [2:0]       dly_cnt_q, dly_cnt_d;
  logic [10:0]      len_q, len_d;
  logic [3:0]       idle_q, idle_d;
  logic [15:0]      drop_q, drop_d;
  logic [7:0]       pdata_q, pdata_d;
  logic             pvalid_q, pvalid_d;
  logic             pfirst_q, pfirst_d;
  logic             fend_q, fend_d;
  logic [10:0]      flen_q, flen_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic             drop_inc;
  logic             idle_hit;
  logic             mac_ok;

`ifdef RX_MAC_FILTER_EN
  logic [47:0] dst_q, dst_d;
  assign mac_ok = (dst_q == LOCAL_MAC) || (dst_q == 48'hFF_FF_FF_FF_FF_FF);
`else
  logic unused_local_mac;
  assign unused_local_mac = ^LOCAL_MAC;
  assign mac_ok = 1'b1;
`endif

  assign idle_hit = !dataValidIn && (idle_q == IDLE_LAST);

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    hdr_cnt_d  = hdr_cnt_q;
    etype_hi_d = etype_hi_q;
    dly_d      = dly_q;
    dly_cnt_d  = dly_cnt_q;
    len_d      = len_q;
    pdata_d    = pdata_q;
    pvalid_d   = 1'b0;
    pfirst_d   = 1'b0;
    fend_d     = 1'b0;
    flen_d     = flen_q;
    ferr_d     = ferr_q;
    drop_inc   = 1'b0;
`ifdef RX_MAC_FILTER_EN
    dst_d      = dst_q;
`endif
    // The idle counter only runs inside a frame; IDLE keeps it at zero.
    idle_d = (dataValidIn || state_q == S_IDLE) ? 4'd0 : idle_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (dataValidIn) begin
          if (dataIn == 8'h55) begin
            state_d   = S_PRE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_PRE: begin
        if (dataValidIn) begin
          if (dataIn == 8'h55) begin
            if (pre_cnt_q == 3'd7) begin
              state_d  = S_DROP;
              drop_inc = 1'b1;
            end else begin
              pre_cnt_d = pre_cnt_q + 3'd1;
            end
          end else if (dataIn == 8'hD5) begin
            state_d   = S_HDR;
            hdr_cnt_d = 4'd0;
          end else begin
            state_d  = S_DROP;
            drop_inc = 1'b1;
          end
        end else if (idle_hit) begin
          state_d  = S_IDLE;
          drop_inc = 1'b1;
        end
      end
      S_HDR: begin
        if (dataValidIn) begin
          hdr_cnt_d  = hdr_cnt_q + 4'd1;
          etype_hi_d = dataIn;
`ifdef RX_MAC_FILTER_EN
          if (hdr_cnt_q < 4'd6) dst_d = {dst_q[39:0], dataIn};
`endif
          if (hdr_cnt_q == 4'd13) begin
            if ({etype_hi_q, dataIn} == ETHERTYPE && mac_ok) begin
              state_d   = S_PAY;
              len_d     = 11'd0;
              dly_cnt_d = 3'd0;
            end else begin
              state_d  = S_DROP;
              drop_inc = 1'b1;
            end
          end
        end else if (idle_hit) begin
          state_d  = S_IDLE;
          drop_inc = 1'b1;
        end
      end
      S_PAY: begin
        if (dataValidIn) begin
          // Newest byte enters at index 0; the oldest sits at index 3 once full.
          dly_d = {dly_q[2:0], dataIn};
          if (dly_cnt_q == 3'd4) begin
            if (len_q == MAX_LEN) begin
              fend_d  = 1'b1;
              flen_d  = MAX_LEN;
              ferr_d  = 1'b1;
              state_d = S_DROP;
            end else begin
              pdata_d  = dly_q[3];
              pvalid_d = 1'b1;
              pfirst_d = (len_q == 11'd0);
              len_d    = len_q + 11'd1;
            end
          end else begin
            dly_cnt_d = dly_cnt_q + 3'd1;
          end
        end else if (idle_hit) begin
          fend_d  = 1'b1;
          flen_d  = len_q;
          ferr_d  = (len_q < MIN_LEN);
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (idle_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      hdr_cnt_q  <= '0;
      etype_hi_q <= '0;
      dly_q      <= '0;
      dly_cnt_q  <= '0;
      len_q      <= '0;
      idle_q     <= '0;
      drop_q     <= '0;
      pdata_q    <= '0;
      pvalid_q   <= 1'b0;
      pfirst_q   <= 1'b0;
      fend_q     <= 1'b0;
      flen_q     <= '0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef RX_MAC_FILTER_EN
      dst_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      hdr_cnt_q  <= hdr_cnt_d;
      etype_hi_q <= etype_hi_d;
      dly_q      <= dly_d;
      dly_cnt_q  <= dly_cnt_d;
      len_q      <= len_d;
      idle_q     <= idle_d;
      drop_q     <= drop_d;
      pdata_q    <= pdata_d;
      pvalid_q   <= pvalid_d;
      pfirst_q   <= pfirst_d;
      fend_q     <= fend_d;
      flen_q     <= flen_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
`ifdef RX_MAC_FILTER_EN
      dst_q      <= dst_d;
`endif
    end
  end

  assign payloadDataOut  = pdata_q;
  assign payloadValidOut = pvalid_q;
  assign payloadFirstOut = pfirst_q;
  assign frameEndOut     = fend_q;
  assign frameLenOut     = flen_q;
  assign frameErrOut     = ferr_q;
  assign dropCntOut      = drop_q;
  assign busyOut         = busy_q;

endmodule

// File: tb/tb_rx_frame_seq.sv
// Scoreboard bench for rx_frame_seq: stimulus pushes expected payload/end events,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_rx_frame_seq;

  logic        clk = 1'b0;
  logic        rstIn;
  logic [7:0]  dataIn;
  logic        dataValidIn;
  logic [7:0]  payloadDataOut;
  logic        payloadValidOut;
  logic        payloadFirstOut;
  logic        frameEndOut;
  logic [10:0] frameLenOut;
  logic        frameErrOut;
  logic [15:0] dropCntOut;
  logic        busyOut;

  typedef struct packed {
    logic        is_end;
    logic        first;
    logic [7:0]  data;
    logic [10:0] len;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   exp_drop = 0;

  localparam logic [47:0] MAC_LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MAC_OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] MAC_BCAST = 48'hFF_FF_FF_FF_FF_FF;

  rx_frame_seq dut (
    .clkIn(clk), .rstIn(rstIn), .dataIn(dataIn), .dataValidIn(dataValidIn),
    .payloadDataOut(payloadDataOut), .payloadValidOut(payloadValidOut),
    .payloadFirstOut(payloadFirstOut), .frameEndOut(frameEndOut),
    .frameLenOut(frameLenOut), .frameErrOut(frameErrOut),
    .dropCntOut(dropCntOut), .busyOut(busyOut)
  );

  always #2 clk = ~clk;

  always @(negedge clk) begin
    if (payloadValidOut && frameEndOut) begin
      total++; bad++;
      $display("FAIL overlap: payloadValidOut and frameEndOut both high at %0t", $time);
    end else if (payloadValidOut || frameEndOut) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected: valid=%0b data=%02h end=%0b len=%0d err=%0b, required nothing",
                 payloadValidOut, payloadDataOut, frameEndOut, frameLenOut, frameErrOut);
      end else begin
        mon_e = exp_q.pop_front();
        if (payloadValidOut) begin
          if (mon_e.is_end || payloadDataOut !== mon_e.data || payloadFirstOut !== mon_e.first) begin
            bad++;
            $display("FAIL payload: got data=%02h first=%0b, required is_end=%0b data=%02h first=%0b",
                     payloadDataOut, payloadFirstOut, mon_e.is_end, mon_e.data, mon_e.first);
          end else begin
            $display("ok payload data=%02h first=%0b", payloadDataOut, payloadFirstOut);
          end
        end else begin
          if (!mon_e.is_end || frameLenOut !== mon_e.len || frameErrOut !== mon_e.err) begin
            bad++;
            $display("FAIL frame_end: got len=%0d err=%0b, required is_end=%0b len=%0d err=%0b",
                     frameLenOut, frameErrOut, mon_e.is_end, mon_e.len, mon_e.err);
          end else begin
            $display("ok frame_end len=%0d err=%0b", frameLenOut, frameErrOut);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("ok %s = %0h", name, act);
    end
  endtask

  task automatic push_bytes(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.data  = 8'(i);
      e.first = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_end(input int len, input logic err);
    exp_t e;
    e = '0;
    e.is_end = 1'b1;
    e.len    = 11'(len);
    e.err    = err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    dataValidIn = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic put(input logic [7:0] b, input int gap);
    dataValidIn = 1'b1;
    dataIn      = b;
    @(posedge clk); #1;
    dataValidIn = 1'b0;
    idle(gap);
  endtask

  task automatic send_head(input logic [47:0] dst, input logic [15:0] et, input int npre, input int gap);
    for (int i = 0; i < npre; i++) put(8'h55, gap);
    put(8'hD5, gap);
    for (int k = 5; k >= 0; k--) put(dst[k*8 +: 8], gap);
    for (int k = 0; k < 6; k++) put(8'(8'h30 + k), gap);
    put(et[15:8], gap);
    put(et[7:0], gap);
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int npay,
                            input int gap, input int npre);
    send_head(dst, et, npre, gap);
    for (int i = 0; i < npay; i++) put(8'(i), gap);
    for (int k = 0; k < 4; k++) put(8'(8'hA0 + k), gap);
    idle(8);
  endtask

  task automatic good_frame(input logic [47:0] dst, input int n, input int gap);
    push_bytes(n);
    push_end(n, 1'b0);
    send_frame(dst, 16'h0800, n, gap, 7);
  endtask

  initial begin
    rstIn = 1'b1;
    dataIn = 8'h00;
    dataValidIn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstIn = 1'b0;
    check("rst_payloadData", 32'(payloadDataOut), 32'h0);
    check("rst_payloadValid", 32'(payloadValidOut), 32'h0);
    check("rst_payloadFirst", 32'(payloadFirstOut), 32'h0);
    check("rst_frameEnd", 32'(frameEndOut), 32'h0);
    check("rst_frameLen", 32'(frameLenOut), 32'h0);
    check("rst_frameErr", 32'(frameErrOut), 32'h0);
    check("rst_dropCnt", 32'(dropCntOut), 32'h0);
    check("rst_busy", 32'(busyOut), 32'h0);

    good_frame(MAC_LOCAL, 60, 0);
    check("good_len_hold", 32'(frameLenOut), 32'd60);
    check("good_err_hold", 32'(frameErrOut), 32'd0);
    check("good_drop", 32'(dropCntOut), 32'(exp_drop));
    check("idle_busy", 32'(busyOut), 32'd0);

    send_frame(MAC_LOCAL, 16'h86DD, 60, 0, 7);
    exp_drop++;
    check("etype_drop", 32'(dropCntOut), 32'(exp_drop));
    good_frame(MAC_LOCAL, 60, 0);

    put(8'h12, 0);
    idle(8);
    check("idle_garbage_drop", 32'(dropCntOut), 32'(exp_drop));

    send_frame(MAC_LOCAL, 16'h0800, 60, 0, 8);
    exp_drop++;
    check("pre8_drop", 32'(dropCntOut), 32'(exp_drop));

    push_bytes(1500);
    push_end(1500, 1'b1);
    send_frame(MAC_LOCAL, 16'h0800, 1600, 0, 7);
    good_frame(MAC_LOCAL, 60, 0);

    good_frame(MAC_LOCAL, 60, 1);
    good_frame(MAC_LOCAL, 60, 3);

    push_bytes(20);
    push_end(20, 1'b1);
    send_frame(MAC_LOCAL, 16'h0800, 20, 0, 7);
    check("runt_err_hold", 32'(frameErrOut), 32'd1);

    push_bytes(20);
    send_head(MAC_LOCAL, 16'h0800, 7, 0);
    for (int i = 0; i < 24; i++) put(8'(i), 0);
    rstIn = 1'b1;
    @(posedge clk); #1;
    rstIn = 1'b0;
    exp_drop = 0;
    check("midrst_valid", 32'(payloadValidOut), 32'h0);
    check("midrst_data", 32'(payloadDataOut), 32'h0);
    check("midrst_first", 32'(payloadFirstOut), 32'h0);
    check("midrst_len", 32'(frameLenOut), 32'h0);
    check("midrst_err", 32'(frameErrOut), 32'h0);
    check("midrst_drop", 32'(dropCntOut), 32'h0);
    check("midrst_busy", 32'(busyOut), 32'h0);
    idle(8);
    good_frame(MAC_LOCAL, 60, 0);

`ifdef RX_MAC_FILTER_EN
    send_frame(MAC_OTHER, 16'h0800, 60, 0, 7);
    exp_drop++;
`else
    good_frame(MAC_OTHER, 60, 0);
`endif
    check("mac_other_drop", 32'(dropCntOut), 32'(exp_drop));
    good_frame(MAC_BCAST, 60, 0);
    check("mac_bcast_drop", 32'(dropCntOut), 32'(exp_drop));

    idle(20);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_seq.md
# rx_frame_seq

Receive-side frame sequencer on the 250 MHz read side of the RX CDC FIFO. It consumes the FIFO's byte/valid stream and finds frame boundaries from preamble, SFD and idle gaps. It checks the Ethernet header, strips preamble, header and FCS, and presents payload bytes with frame start/end markers to the downstream book-update parser. Frames it rejects are dropped and counted.

## Interface
Parameters:
- `IDLE_TIMEOUT`, default 4: consecutive idle cycles that close a frame; legal range 2..15.
- `ETHERTYPE`, default 16'h0800: accepted EtherType.
- `MAX_PAYLOAD`, default 1500: maximum emitted payload bytes per frame.
- `MIN_PAYLOAD`, default 46: frames with fewer payload bytes are runts.
- `LOCAL_MAC`, default 48'h02_00_00_00_00_01: destination filter address; used only with the filter macro.

Ports (one clock; reset is synchronous and active-high):
- `clkIn`, in, 1: 250 MHz read-side clock.
- `rstIn`, in, 1: synchronous active-high reset.
- `dataIn`, in, 8: byte from the CDC FIFO read port.
- `dataValidIn`, in, 1: `dataIn` is valid this cycle; there is no backpressure.
- `payloadDataOut`, out, 8: payload byte.
- `payloadValidOut`, out, 1: `payloadDataOut` is valid.
- `payloadFirstOut`, out, 1: asserted with the first payload byte of a frame.
- `frameEndOut`, out, 1: one-cycle pulse marking the end of an accepted frame.
- `frameLenOut`, out, 11: count of emitted payload bytes; valid with `frameEndOut`.
- `frameErrOut`, out, 1: frame was a runt or oversize; valid with `frameEndOut`.
- `dropCntOut`, out, 16: count of rejected frames; saturates at 16'hFFFF.
- `busyOut`, out, 1: state is not IDLE.

## Operation
- **States:** IDLE, PRE, HDR, PAY, DROP.
- **IDLE:**
  - Valid 0x55 → PRE with preamble count 1.
  - Any other valid byte → DROP; the drop counter does not increment.
- **PRE:**
  - 0x55 increments the preamble count.
  - An 8th 0x55 → DROP.
  - 0xD5 → HDR.
  - Any other byte → DROP.
  - Drop counter increments on both DROP transitions from PRE.
- **HDR:**
  - Captures 14 bytes: destination MAC, source MAC, EtherType (big-endian).
  - On the 14th byte: EtherType equal to `ETHERTYPE` (and MAC accepted, see Configuration) → PAY.
  - Otherwise → DROP and the drop counter increments.
- **PAY:**
  - Each valid byte enters a 4-entry delay line.
  - Once the delay line holds 4 bytes, each new byte pushes the oldest byte out to the payload output.
  - The 4 bytes left in the delay line at frame end are the FCS and are discarded; the FCS is not checked.
- **Oversize:** if a byte would be emitted after `MAX_PAYLOAD` bytes have already gone out:
  - Pulse `frameEndOut` with `frameLenOut` = `MAX_PAYLOAD` and `frameErrOut` = 1.
  - Go to DROP.
- **Idle counter:**
  - Counts consecutive cycles with `dataValidIn` = 0 in PRE, HDR, PAY and DROP.
  - Clears on any valid byte.
  - On reaching `IDLE_TIMEOUT`:
    - PAY → pulse `frameEndOut`; `frameErrOut` = 1 if length < `MIN_PAYLOAD`. Go to IDLE.
    - PRE or HDR → drop counter increments, go to IDLE.
    - DROP → IDLE.
- **Length counter:** 11 bits, cleared on entry to PAY, incremented per emitted byte.
- **Reset (including mid-frame):**
  - Next edge: state IDLE, delay line and counters cleared, `dropCntOut` = 0.
  - No `frameEndOut` is issued for the interrupted frame.

## Timing
- All outputs are registered.
- Reset values: `payloadDataOut` 0, `payloadValidOut` 0, `payloadFirstOut` 0, `frameEndOut` 0, `frameLenOut` 0, `frameErrOut` 0, `dropCntOut` 0, `busyOut` 0.
- Payload byte N is emitted one cycle after the edge that accepts byte N+4 of the payload field.
- `frameEndOut` asserts one cycle after the `IDLE_TIMEOUT`-th consecutive idle cycle.
- `frameEndOut` never coincides with `payloadValidOut`.
- `frameLenOut` and `frameErrOut` hold their values until the next `frameEndOut`.
- Input cadence may be back-to-back or every other cycle (the normal 125 → 250 MHz case); single-cycle gaps never close a frame.
- A valid byte arriving in the same cycle the idle counter would expire clears the counter, so the frame continues.

## Configuration
- **`RX_MAC_FILTER_EN` defined:**
  - HDR accepts only destination MAC == `LOCAL_MAC` or 48'hFF_FF_FF_FF_FF_FF.
  - Any other destination → DROP, and the drop counter increments.
- **`RX_MAC_FILTER_EN` undefined:** destination MAC is ignored; only EtherType is checked.

## Test plan
- **Good frame:** 7×0x55, 0xD5, header with EtherType 0x0800, payload 0x00..0x3B (60 bytes), 4 FCS bytes, then 8 idle cycles → 60 payload bytes 0x00..0x3B in order; `payloadFirstOut` with 0x00; one `frameEndOut` with len 60, err 0.
- **Wrong EtherType:** same frame with EtherType 0x86DD → no `payloadValidOut`, no `frameEndOut`, `dropCntOut` 0→1; the following good frame is accepted.
- **Oversize:** 1600 payload bytes → 1500 bytes emitted; `frameEndOut` with len 1500, err 1; remainder dropped; next frame accepted.
- **Cadence and runt:**
  - Good frame with input valid every other cycle, `IDLE_TIMEOUT`=4 → frame not split; len 60.
  - A 20-byte payload → `frameEndOut` with len 20, err 1.
- **Reset mid-payload:** assert `rstIn` after 20 payload bytes → all outputs 0 on the next cycle, no `frameEndOut`; the next good frame is output intact.
- **MAC filter:**
  - With `RX_MAC_FILTER_EN`: destination 02:00:00:00:00:02 dropped (count +1); broadcast and `LOCAL_MAC` accepted.
  - Without the macro: the 02:00:00:00:00:02 frame is accepted.
